seq_detector_moore_param: RTL and testbench
===========================================

// Module: seq_detector_moore_param
// PURPOSE
//   Parametrised Moore serial-pattern detector with a saturating match counter.
//   Pattern, length and overlap mode are set per instance, so one RTL body
//   replaces the per-pattern hand-coded detectors.
//   Sits on a 1-bit serial input stream gated by a qualifier (en).
//   Drives a registered-state detect flag plus an event count for status logic.
// PARAMETERS
//   LEN      4        pattern length in bits, 1..16
//   PATTERN  4'b1100  pattern [LEN-1:0]; PATTERN[LEN-1] is the first bit received
//   OVERLAP  0        0 = non-overlapping (restart after a hit), 1 = overlapping
//   CNT_W    8        match counter width, >= 1
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   x          in   1      serial data bit, sampled only when en=1
//   en         in   1      bit qualifier; en=0 holds all state
//   clr_count  in   1      synchronous clear of match_count
//   z          out  1      Moore detect flag: 1 only while state == LEN
//   match_count out CNT_W  number of detects, saturating at 2**CNT_W-1
// BEHAVIOUR
//   Reset (async, rst=1): state=0, z=0, match_count=0. Takes effect immediately,
//     including mid-pattern; the partial match is discarded.
//   State encoding: state = number of pattern bits currently matched.
//     Range 0..LEN, width SW = $clog2(LEN+2).
//     Out-of-range encodings recover to state 0 on the next enabled cycle.
//   Next state, from state s < LEN with input bit b:
//     w = first s pattern bits followed by b.
//     next = length of the longest prefix of PATTERN that is a suffix of w.
//     This is the KMP failure transition, evaluated at elaboration.
//   From s == LEN:
//     OVERLAP=1: same rule with w = full pattern followed by b.
//     OVERLAP=0: treated exactly as s == 0.
//   For PATTERN=1100, OVERLAP=0 this gives:
//     0:x0->0/x1->1   1:0->0/1->2   2:0->3/1->2   3:0->4/1->1   4:0->0/1->1
//   en=0: state, z and match_count hold, whatever the value of x.
//   Output z:
//     Decoded from the state register only; no combinational path from x.
//     z=1 for exactly one enabled cycle per detect.
//     Rises on the clk edge after the edge that samples the final pattern bit.
//     Stays 1 while en=0 and state == LEN.
//   match_count:
//     Increments by 1 on each enabled clock edge where next state == LEN.
//     The increment lands on the same edge that z rises.
//     Saturates at all-ones; it does not wrap.
//   clr_count=1: match_count <= 0 on that edge, regardless of en.
//     Clear wins over a simultaneous increment (result 0; that detect is not counted).
//     clr_count does not affect state or z.
//   LEN=1: state toggles 0/1.
//     PATTERN=1 gives z = x delayed one enabled cycle.
//     With OVERLAP=0, consecutive hits are still detected back-to-back.
// STRUCTURE
//   Package seq_det_pkg holds:
//     - function seq_next_state(s, b, LEN, PATTERN, OVERLAP)
//     - localparam helper for SW
//     - MAX_LEN=16 constant
//   Top holds the state register, the next-state case built from the function,
//   and the z decode.
//   Sub-module seq_match_counter #(CNT_W) holds the saturating counter.
//     Ports: clk, rst, inc, clr, count.
// TESTING
//   1. PATTERN=1100, OVERLAP=0, en=1; x=1,1,0,0,1,1,0,0
//      -> z=1 in cycles 5 and 9 (1-based, cycle after 4th/8th bit); match_count=2.
//   2. PATTERN=1010; x=1,0,1,0,1,0,1
//      -> OVERLAP=1: z after bits 4 and 6, count=2; OVERLAP=0: z after bit 4 only, count=1.
//   3. PATTERN=1100, x=1,1,0 with en=1, then en=0 for 3 cycles with x toggling,
//      then en=1 with x=0
//      -> state holds at 3; z=1 one cycle after the final 0.
//   4. CNT_W=2, five non-overlapping 1100 hits -> match_count = 1,2,3,3,3.
//      Then clr_count=1 on the edge of a 6th hit -> match_count=0 and z=1.
//   5. PATTERN=1100 after x=1,1,0; assert rst asynchronously between edges
//      -> z=0, count=0 immediately; next 1,1,0,0 detects normally.
//   6. Random 10k-bit stream against a reference string-matcher model,
//      for LEN in {1,3,4,7}, both OVERLAP values
//      -> z and match_count match every cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and the elaboration-time transition function for the
// parametrised serial pattern detector.
package seq_det_pkg;

  localparam int MAX_LEN = 16;
  localparam int PIW     = $clog2(MAX_LEN);
  localparam int WIW     = $clog2(MAX_LEN + 1);

  // State register width: encodes 0..len with at least one spare code.
  function automatic int seq_sw(input int len);
    return $clog2(len + 2);
  endfunction

  // KMP failure transition: longest pattern prefix that is a suffix of
  // (first s pattern bits, then b). pattern[len-1] is the first bit received.
  function automatic int seq_next_state(input int s, input logic b, input int len,
                                        input logic [MAX_LEN-1:0] pattern,
                                        input bit overlap);
    logic [MAX_LEN:0] w;
    int               s_eff;
    int               m;
    int               res;
    bit               ok;
    s_eff = (s == len && !overlap) ? 0 : s;
    if (s_eff > len) begin
      return 0;
    end
    w = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < s_eff) begin
        w[WIW'(i)] = pattern[PIW'(len - 1 - i)];
      end
    end
    w[WIW'(s_eff)] = b;
    m   = s_eff + 1;
    res = 0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      if (k <= len && k <= m) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k && w[WIW'(m - k + j)] != pattern[PIW'(len - 1 - j)]) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          res = k;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Count updates on the edge that samples inc/clr; no backpressure.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore pattern detector on a qualified serial stream.
// z is decoded from the state register, one enabled cycle after the last bit.
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1100,
  parameter bit             OVERLAP = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             clr_count,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int                   SW      = seq_sw(LEN);
  localparam int                   NS      = 2 ** SW;
  localparam logic [MAX_LEN-1:0]   PAT_EXT = MAX_LEN'(PATTERN);
  localparam logic [SW-1:0]        FULL    = SW'(LEN);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic          hit;

  // Transition table is constant; unused codes map to 0 so stray states recover.
  for (genvar s = 0; s < NS; s++) begin : g_tbl
    localparam logic [SW-1:0] N0 = SW'(seq_next_state(s, 1'b0, LEN, PAT_EXT, OVERLAP));
    localparam logic [SW-1:0] N1 = SW'(seq_next_state(s, 1'b1, LEN, PAT_EXT, OVERLAP));
    assign nxt0[s] = N0;
    assign nxt1[s] = N1;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = x ? nxt1[state_q] : nxt0[state_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign z   = (state_q == FULL);
  assign hit = en && (state_d == FULL);

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (clr_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Scoreboarded bench: several detector configurations share one stimulus
// stream and are compared each cycle against a sliding-window string matcher.
module tb_seq_detector_moore_param;

  localparam int NI = 11;
  localparam int        LENS [NI] = '{4, 4, 4, 4, 4, 1, 1, 3, 3, 7, 7};
  localparam logic [15:0] PATS [NI] = '{16'hC, 16'hC, 16'hA, 16'hA, 16'hC, 16'h1, 16'h1,
                                        16'h5, 16'h5, 16'h6D, 16'h6D};
  localparam bit        OVS  [NI] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                        1'b0, 1'b1, 1'b0, 1'b1};
  localparam int        CWS  [NI] = '{8, 8, 8, 8, 2, 8, 8, 8, 8, 8, 8};

  typedef struct packed {
    logic [NI-1:0]      z;
    logic [NI-1:0][7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, x, en, clr_count;
  logic [NI-1:0] dut_z;
  logic [7:0]    dut_cnt [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t        sb [$];
  logic [15:0] m_sh  [NI];
  int          m_nb  [NI];
  logic        m_z   [NI];
  int          m_cnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CWS[g]-1:0] cnt_w;
    seq_detector_moore_param #(
      .LEN     (LENS[g]),
      .PATTERN (PATS[g][LENS[g]-1:0]),
      .OVERLAP (OVS[g]),
      .CNT_W   (CWS[g])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .x           (x),
      .en          (en),
      .clr_count   (clr_count),
      .z           (dut_z[g]),
      .match_count (cnt_w)
    );
    assign dut_cnt[g] = 8'(cnt_w);
  end

  // Reference: keep the most recent bits since the last restart and compare
  // the newest LEN of them against the pattern.
  task automatic model_update(input logic b, input logic e, input logic c, input logic r);
    int  mask;
    bit  hit;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_sh[i] = '0; m_nb[i] = 0; m_z[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        hit = 1'b0;
        if (e) begin
          m_sh[i] = {m_sh[i][14:0], b};
          if (m_nb[i] < 16) m_nb[i]++;
          mask = (1 << LENS[i]) - 1;
          hit = (m_nb[i] >= LENS[i]) && ((int'(m_sh[i]) & mask) == int'(PATS[i]));
          m_z[i] = hit;
          if (hit && !OVS[i]) m_nb[i] = 0;
        end
        if (c) m_cnt[i] = 0;
        else if (hit && m_cnt[i] < (1 << CWS[i]) - 1) m_cnt[i]++;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e.z[i]   = m_z[i];
      e.cnt[i] = 8'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic b, input logic e, input logic c, input logic r);
    @(negedge clk);
    #1;
    x = b; en = e; clr_count = c; rst = r;
    model_update(b, e, c, r);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
          n_cmp++;
          if (dut_z[i] !== e.z[i] || dut_cnt[i] !== e.cnt[i]) begin
            n_fail++;
            $display("FAIL sb inst%0d @%0t: z=%0b cnt=%0d, expected z=%0b cnt=%0d",
                     i, $time, dut_z[i], dut_cnt[i], e.z[i], e.cnt[i]);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] zv;
    logic [6:0] zc, zd;
    logic [4:0] z5;
    logic [7:0] t1_bits;
    logic [6:0] t2_bits;
    int         exp4 [5];
    exp4 = '{1, 2, 3, 3, 3};
    t1_bits = 8'b1100_1100;
    t2_bits = 7'b1010101;
    rst = 1'b1; x = 1'b0; en = 1'b0; clr_count = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_sh[i] = '0; m_nb[i] = 0; m_z[i] = 1'b0; m_cnt[i] = 0;
    end

    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_z", int'(dut_z[0]), 0);
    chk("reset_cnt", int'(dut_cnt[0]), 0);

    // 1100 non-overlapping, two back-to-back occurrences
    for (int i = 0; i < 8; i++) begin
      step(t1_bits[7-i], 1'b1, 1'b0, 1'b0);
      zv[i] = dut_z[0];
    end
    chk("t1_z_trace", int'(zv), 8'b1000_1000);
    chk("t1_cnt", int'(dut_cnt[0]), 2);

    // 1010 overlapping versus non-overlapping
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(t2_bits[6-i], 1'b1, 1'b0, 1'b0);
      zc[i] = dut_z[2];
      zd[i] = dut_z[3];
    end
    chk("t2_ov1_z", int'(zc), 7'b0101000);
    chk("t2_ov0_z", int'(zd), 7'b0001000);
    chk("t2_ov1_cnt", int'(dut_cnt[2]), 2);
    chk("t2_ov0_cnt", int'(dut_cnt[3]), 1);

    // en=0 holds state while x toggles
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_hold_z", int'(dut_z[0]), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_z", int'(dut_z[0]), 1);
    chk("t3_cnt", int'(dut_cnt[0]), 1);

    // Saturation on a 2-bit counter, then clear colliding with a hit
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t4_sat_cnt%0d", k), int'(dut_cnt[4]), exp4[k]);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_clr_cnt", int'(dut_cnt[4]), 0);
    chk("t4_clr_z", int'(dut_z[4]), 1);

    // Asynchronous reset mid-pattern
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_z", int'(dut_z[0]), 0);
    chk("t5_async_cnt", int'(dut_cnt[0]), 0);
    model_update(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    z5[0] = dut_z[0];
    step(1'b1, 1'b1, 1'b0, 1'b0);
    z5[1] = dut_z[0];
    step(1'b1, 1'b1, 1'b0, 1'b0);
    z5[2] = dut_z[0];
    step(1'b0, 1'b1, 1'b0, 1'b0);
    z5[3] = dut_z[0];
    step(1'b0, 1'b1, 1'b0, 1'b0);
    z5[4] = dut_z[0];
    chk("t5_after_z", int'(z5), 5'b10000);
    chk("t5_after_cnt", int'(dut_cnt[0]), 1);

    // Random stream shared by every configuration
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 499) == 0), 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
